// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for mac_result_writer (FSM state, data widths, parameter defaults).
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WRITE,
        DONE
    } state_t;

    localparam int ACC_W  = 18;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam int DEF_N_TERMS     = 4;
    localparam int DEF_NUM_RESULTS = 8;
    localparam int DEF_BASE_ADDR   = 2;

endpackage

// File: rtl/mac_datapath.sv
// mac_datapath: 8x8 unsigned multiplier feeding an 18-bit accumulator, with saturating or truncating 16-bit result.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear accumulator (has priority over add_i)
//   add_i      : accumulate a_i*b_i this cycle
//   a_i, b_i   : unsigned operands
//   result_o   : 16-bit view of (accumulator + current product), i.e. the value after this cycle's add
//   Macro MAC_SAT_EN selects saturation to 16'hFFFF instead of dropping the upper bits.
module mac_datapath
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [7:0]        a_i,
    input  logic [7:0]        b_i,
    output logic [DATA_W-1:0] result_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // The result is taken from the running sum so the last pair's product lands in the same cycle it is accepted.
    assign sum   = acc_q + {2'b00, {8'b0, a_i} * {8'b0, b_i}};
    assign acc_d = clr_i ? '0 : (add_i ? sum : acc_q);

`ifdef MAC_SAT_EN
    assign result_o = (|sum[ACC_W-1:DATA_W]) ? '1 : sum[DATA_W-1:0];
`else
    assign result_o = sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/mac_result_writer.sv
// mac_result_writer: accumulates N_TERMS operand products per result and writes NUM_RESULTS results to a register file.
//   Inputs : clk, rst_n (async active-low), start, a_in, b_in, in_valid
//   Outputs: in_ready, mac_en, wr (0 = write), address, din, busy, done -- all registered
//   Macro MAC_SAT_EN (in mac_datapath) saturates din at 16'hFFFF instead of truncating.
module mac_result_writer
    import mac_pkg::*;
#(
    parameter int N_TERMS     = DEF_N_TERMS,
    parameter int NUM_RESULTS = DEF_NUM_RESULTS,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        a_in,
    input  logic [7:0]        b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mac_en,
    output logic              wr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] LAST_TERM = 2'(N_TERMS - 1);
    localparam logic [2:0] LAST_IDX  = 3'(NUM_RESULTS - 1);

    state_t            state_q, state_d;
    logic [1:0]        term_q, term_d;
    logic [2:0]        idx_q, idx_d;
    logic              in_ready_q, in_ready_d;
    logic              mac_en_q, mac_en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              acc_clr, acc_add;
    logic [DATA_W-1:0] result;

    mac_datapath u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (acc_clr),
        .add_i    (acc_add),
        .a_i      (a_in),
        .b_i      (b_in),
        .result_o (result)
    );

    always_comb begin
        state_d    = state_q;
        term_d     = term_q;
        idx_d      = idx_q;
        in_ready_d = in_ready_q;
        mac_en_d   = 1'b0;
        wr_d       = 1'b1;
        address_d  = address_q;
        din_d      = din_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d    = ACC;
                busy_d     = 1'b1;
                in_ready_d = 1'b1;
                term_d     = '0;
                idx_d      = '0;
                acc_clr    = 1'b1;
            end
            ACC: if (in_valid && in_ready_q) begin
                acc_add = 1'b1;
                term_d  = term_q + 2'd1;
                // Last pair: register the strobe now so mac_en is high for exactly the WRITE cycle.
                if (term_q == LAST_TERM) begin
                    state_d    = WRITE;
                    in_ready_d = 1'b0;
                    mac_en_d   = 1'b1;
                    wr_d       = 1'b0;
                    address_d  = ADDR_W'(BASE_ADDR) + {1'b0, idx_q};
                    din_d      = result;
                end
            end
            WRITE: begin
                acc_clr = 1'b1;
                term_d  = '0;
                idx_d   = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ACC;
                    in_ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            term_q     <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            mac_en_q   <= 1'b0;
            wr_q       <= 1'b1;
            address_q  <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            term_q     <= term_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            mac_en_q   <= mac_en_d;
            wr_q       <= wr_d;
            address_q  <= address_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mac_en   = mac_en_q;
    assign wr       = wr_q;
    assign address  = address_q;
    assign din      = din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// tb_mac_result_writer: directed self-checking bench for mac_result_writer (default and 1x1 configurations).
module tb_mac_result_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0;
    logic [7:0]  a_in = '0, b_in = '0;
    logic        in_ready, mac_en, wr, busy, done;
    logic [3:0]  address;
    logic [15:0] din;

    logic        start1 = 1'b0, in_valid1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        in_ready1, mac_en1, wr1, busy1, done1;
    logic [3:0]  address1;
    logic [15:0] din1;

    int checks = 0, errors = 0, bad = 0, dn = 0;
    logic [3:0]  wa[$];
    logic [15:0] wd[$];
    logic [7:0]  ta[4], tb_b[4];

    always #5 clk = ~clk;

    mac_result_writer u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready), .mac_en(mac_en), .wr(wr),
        .address(address), .din(din), .busy(busy), .done(done)
    );

    mac_result_writer #(.N_TERMS(1), .NUM_RESULTS(1), .BASE_ADDR(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
        .in_valid(in_valid1), .in_ready(in_ready1), .mac_en(mac_en1), .wr(wr1),
        .address(address1), .din(din1), .busy(busy1), .done(done1)
    );

    always @(negedge clk) begin
        if (mac_en) begin
            wa.push_back(address);
            wd.push_back(din);
        end
        if (mac_en && wr) bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] a0, a1v, a2, a3, b0, b1v, b2, b3);
        ta[0] = a0; ta[1] = a1v; ta[2] = a2; ta[3] = a3;
        tb_b[0] = b0; tb_b[1] = b1v; tb_b[2] = b2; tb_b[3] = b3;
    endtask

    // Drives one job on u0; gap idle cycles follow each pair, junk adds stray start/in_valid, stop aborts after that many pairs.
    task automatic run_job(input int gap, input bit junk, input int stop);
        int k = 0, g = 0, cyc = 0;
        dn = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (cyc < 2000) begin
            if (stop >= 0 && k == stop) return;
            if (in_ready && k < 32 && g == 0) begin
                in_valid = 1'b1; a_in = ta[k % 4]; b_in = tb_b[k % 4];
                k++; g = gap;
            end else begin
                in_valid = junk && !in_ready; a_in = 8'd99; b_in = 8'd99;
                if (g > 0) g--;
            end
            start = junk && busy;
            @(negedge clk);
            cyc++;
            if (done) dn++;
            if (!busy) break;
        end
        in_valid = 1'b0; start = 1'b0;
        check("timeout", 32'(cyc < 2000), 1);
    endtask

    task automatic check_job(input logic [15:0] exp_din);
        check("write_count", wa.size(), 8);
        for (int i = 0; i < wa.size() && i < 8; i++) begin
            check("addr", 32'(wa[i]), 32'(2 + i));
            check("din", 32'(wd[i]), 32'(exp_din));
        end
        check("done_pulses", dn, 1);
        check("bad_strobe", bad, 0);
        check("busy_after", 32'(busy), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_wr", 32'(wr), 1);
        check("rst_addr", 32'(address), 0);
        check("rst_din", 32'(din), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
    endtask

    initial begin
        logic [15:0] sat_exp;
`ifdef MAC_SAT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'hF804;
`endif
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        set_ops(1, 2, 3, 4, 1, 2, 3, 4);
        wa.delete(); wd.delete();
        run_job(0, 1'b0, -1);
        check_job(16'd30);

        wa.delete(); wd.delete();
        run_job(2, 1'b0, -1);
        check_job(16'd30);

        wa.delete(); wd.delete();
        run_job(0, 1'b1, -1);
        check_job(16'd30);

        set_ops(255, 255, 255, 255, 255, 255, 255, 255);
        wa.delete(); wd.delete();
        run_job(0, 1'b0, -1);
        check_job(sat_exp);

        set_ops(1, 2, 3, 4, 1, 2, 3, 4);
        wa.delete(); wd.delete();
        run_job(0, 1'b0, 22);
        in_valid = 1'b1; a_in = ta[2]; b_in = tb_b[2];
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        check("pre_reset_writes", wa.size(), 5);
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("post_reset_writes", wa.size(), 5);
        wa.delete(); wd.delete();
        run_job(0, 1'b0, -1);
        check_job(16'd30);

        @(negedge clk) begin start1 = 1'b1; in_valid1 = 1'b1; a1 = 8'd7; b1 = 8'd9; end
        @(negedge clk) start1 = 1'b0;
        check("u1_busy", 32'(busy1), 1);
        check("u1_in_ready", 32'(in_ready1), 1);
        check("u1_no_strobe", 32'(mac_en1), 0);
        @(negedge clk) in_valid1 = 1'b0;
        check("u1_mac_en", 32'(mac_en1), 1);
        check("u1_wr", 32'(wr1), 0);
        check("u1_addr", 32'(address1), 2);
        check("u1_din", 32'(din1), 63);
        check("u1_ready_drop", 32'(in_ready1), 0);
        @(negedge clk);
        check("u1_done", 32'(done1), 1);
        check("u1_strobe_end", 32'(mac_en1), 0);
        check("u1_din_hold", 32'(din1), 63);
        check("u1_busy_done", 32'(busy1), 1);
        @(negedge clk);
        check("u1_idle_busy", 32'(busy1), 0);
        check("u1_idle_done", 32'(done1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_writer.md
MAC_RESULT_WRITER -- requirements
Module: mac_result_writer

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, operand pairs accumulated per result (1..4).
REQ-002 SHALL have parameter NUM_RESULTS, default 8, results written per job (1..8).
REQ-003 SHALL have parameter BASE_ADDR, default 2, result-register address of result 0.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle job request, honoured only in IDLE.
REQ-007 SHALL have port a_in  input  8  unsigned operand A.
REQ-008 SHALL have port b_in  input  8  unsigned operand B.
REQ-009 SHALL have port in_valid  input  1  operand pair present.
REQ-010 SHALL have port in_ready  output  1  block accepts operand pair.
REQ-011 SHALL have port mac_en  output  1  result-register access strobe.
REQ-012 SHALL have port wr  output  1  result-register direction; 0 = write, 1 = read/hold.
REQ-013 SHALL have port address  output  4  result-register address.
REQ-014 SHALL have port din  output  16  result data to result register.
REQ-015 SHALL have port busy  output  1  job in progress.
REQ-016 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-017 SHALL implement FSM IDLE, ACC, WRITE, DONE; all outputs registered.
REQ-018 IDLE: start=1 -> ACC, accumulator and result index cleared, busy=1 from the next edge.
REQ-019 ACC: in_ready=1; each cycle with in_valid&in_ready adds a_in*b_in (16-bit unsigned product) to an 18-bit accumulator.
REQ-020 ACC: on acceptance of the N_TERMS-th pair -> WRITE; in_ready drops at that same edge, with no extra pair accepted.
REQ-021 WRITE: for exactly one cycle mac_en=1, wr=0, address=BASE_ADDR+index, din=result; otherwise mac_en=0, wr=1.
REQ-022 After WRITE: index+1; if index was NUM_RESULTS-1 -> DONE, else -> ACC with accumulator cleared.
REQ-023 DONE: done=1 for one cycle, busy=0 at the following edge, -> IDLE.
REQ-024 start outside IDLE SHALL be ignored; in_valid outside ACC SHALL be ignored.
REQ-025 in_valid low in ACC SHALL stall without limit; the accumulator holds.
REQ-026 address and din SHALL hold their last written values outside WRITE.

Reset
REQ-027 rst_n low SHALL force IDLE immediately, with mac_en=0, wr=1, address=0, din=0, in_ready=0, busy=0, done=0, accumulator=0, index=0.
REQ-028 Reset mid-job SHALL abandon the job without any partial write strobe; the next start begins at index 0.

Configuration
REQ-029 With macro MAC_SAT_EN defined, din SHALL be 16'hFFFF when the accumulator exceeds 16'hFFFF, else accumulator[15:0].
REQ-030 Without MAC_SAT_EN, din SHALL be accumulator[15:0], with overflow discarded.

Structure
REQ-031 Package mac_pkg SHALL hold the FSM state typedef, ACC_W=18, DATA_W=16, ADDR_W=4 and the BASE_ADDR/NUM_RESULTS defaults.
REQ-032 Sub-module mac_datapath SHALL contain the multiplier, accumulator and saturation/truncation logic; the FSM stays in mac_result_writer.

Verification
REQ-033 Default parameters, start, pairs (1,1),(2,2),(3,3),(4,4) -> single write strobe with address=2, din=30; repeat for 8 results -> addresses 2..9, then done one pulse.
REQ-034 Pairs (255,255)x4 -> with MAC_SAT_EN din=16'hFFFF; without it din=16'hF804 (260100 mod 65536).
REQ-035 in_valid gapped (1 of 3 cycles) -> same din values as REQ-033, with mac_en never high outside WRITE.
REQ-036 rst_n low during the 3rd operand of result 5 -> all outputs at reset values immediately; a new job writes address 2 first.
REQ-037 start pulsed while busy, plus in_valid during WRITE/DONE -> no effect on results, addresses or pair count.
REQ-038 N_TERMS=1, NUM_RESULTS=1, pair (7,9) -> one write of address 2, din=63, then done; total job length 4 cycles after start.
